// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte buffer behind the UART receiver.
// Bytes flagged by rx_done_tck are queued. The consumer pops them with rd.
// A sticky overflow flag records any byte dropped because the FIFO was full.
module uart_rx_fifo #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tck,
  input  logic [DBIT-1:0]   din,
  input  logic              rd,
  input  logic              clr_overflow,
  output logic [DBIT-1:0]   dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              wr_en;
  logic              rd_en;
  logic              ovf_set;

  // Acceptance decode. A pop in the same cycle frees the slot a full-FIFO write needs.
  // rd while empty is simply ignored.
  always_comb begin
    wr_en   = rx_done_tck & (~full | rd);
    rd_en   = rd & ~empty;
    ovf_set = rx_done_tck & full & ~rd;
  end

  // Storage array; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= din;
  end

  // Pointers, occupancy and sticky overflow. Reset discards everything queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp         <= '0;
      rp         <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      if (wr_en && !rd_en)      count_q <= count_q + 1'b1;
      else if (rd_en && !wr_en) count_q <= count_q - 1'b1;
      // A set and a clear in the same cycle resolve to set.
      if (ovf_set)           overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

  // Outputs derive only from registered state.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_CNT);
    count    = count_q;
    overflow = overflow_q;
    dout     = empty ? '0 : mem[rp];
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: a table of single-cycle vectors, then
// hand-written sequences for fill/wrap, overflow, simultaneous ops and reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tck = 1'b0;
  logic [7:0] din = '0;
  logic       rd = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  uart_rx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .rx_done_tck(rx_done_tck), .din(din), .rd(rd),
    .clr_overflow(clr_overflow), .dout(dout), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] d;
    logic       rdv;
    logic       clr;
    logic [7:0] e_dout;
    logic       e_empty;
    logic       e_full;
    logic [4:0] e_count;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, sample 1 time unit after the active edge.
  task automatic step(input logic r, input logic w, input logic [7:0] d,
                      input logic p, input logic c);
    reset = r; rx_done_tck = w; din = d; rd = p; clr_overflow = c;
    @(posedge clk);
    #1;
    reset = 1'b0; rx_done_tck = 1'b0; din = '0; rd = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_d, input logic e_e,
                         input logic e_f, input logic [4:0] e_c, input logic e_o);
    chk({tag, ".dout"}, int'(dout), int'(e_d));
    chk({tag, ".empty"}, int'(empty), int'(e_e));
    chk({tag, ".full"}, int'(full), int'(e_f));
    chk({tag, ".count"}, int'(count), int'(e_c));
    chk({tag, ".overflow"}, int'(overflow), int'(e_o));
  endtask

  initial begin
    //            rst  wr  din    rd   clr   dout   emp  full cnt  ovf
    vecs[0] = '{1'b1,1'b0,8'h00,1'b0,1'b0, 8'h00,1'b1,1'b0,5'd0,1'b0};
    vecs[1] = '{1'b1,1'b0,8'h00,1'b0,1'b0, 8'h00,1'b1,1'b0,5'd0,1'b0};
    vecs[2] = '{1'b0,1'b0,8'h00,1'b1,1'b0, 8'h00,1'b1,1'b0,5'd0,1'b0};
    vecs[3] = '{1'b0,1'b0,8'h00,1'b1,1'b0, 8'h00,1'b1,1'b0,5'd0,1'b0};
    vecs[4] = '{1'b0,1'b1,8'hA5,1'b0,1'b0, 8'hA5,1'b0,1'b0,5'd1,1'b0};
    vecs[5] = '{1'b0,1'b0,8'h00,1'b1,1'b0, 8'h00,1'b1,1'b0,5'd0,1'b0};
    vecs[6] = '{1'b0,1'b1,8'h33,1'b1,1'b0, 8'h33,1'b0,1'b0,5'd1,1'b0};
    vecs[7] = '{1'b0,1'b0,8'h00,1'b1,1'b0, 8'h00,1'b1,1'b0,5'd0,1'b0};

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].d, vecs[i].rdv, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_empty,
              vecs[i].e_full, vecs[i].e_count, vecs[i].e_ovf);
    end

    // Fill with 0x00..0x0F; head stays 0x00 (dout reads 0x00 but empty=0).
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      chk(".fill.count", int'(count), i + 1);
      chk(".fill.full", int'(full), (i == 15) ? 1 : 0);
    end
    chk(".fill.empty", int'(empty), 0);
    // Pop 8: head before each pop is i.
    for (int i = 0; i < 8; i++) begin
      chk(".wrap.head", int'(dout), i);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk(".wrap.count8", int'(count), 8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk(".wrap.full2", int'(full), 1);
    for (int i = 0; i < 16; i++) begin
      chk(".wrap.order", int'(dout), 8 + i);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk_all("wrap.end", 8'h00, 1'b1, 1'b0, 5'd0, 1'b0);

    // Overflow: refill with 0x00..0x0F, then strobe 0xEE without rd.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    chk_all("ovf.set", 8'h00, 1'b0, 1'b1, 5'd16, 1'b1);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
    chk_all("ovf.setwins", 8'h00, 1'b0, 1'b1, 5'd16, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_all("ovf.clr", 8'h00, 1'b0, 1'b1, 5'd16, 1'b0);

    // Full plus rd and strobe 0x55: pops 0x00, 0x55 lands at the tail.
    step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    chk_all("fullrw", 8'h01, 1'b0, 1'b1, 5'd16, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk(".fullrw.order", int'(dout), (i == 15) ? 8'h55 : i + 1);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk_all("fullrw.end", 8'h00, 1'b1, 1'b0, 5'd0, 1'b0);

    // Reset mid-operation: 5 entries plus a pending overflow-free strobe.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    chk(".mid.count5", int'(count), 5);
    step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    chk_all("mid.reset", 8'h00, 1'b1, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b1, 8'h7E, 1'b0, 1'b0);
    chk_all("mid.after", 8'h7E, 1'b0, 1'b0, 5'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each byte the receiver flags with its one-cycle done strobe and stores it in a first-word-fall-through FIFO. The consumer (command decoder / host bridge) can drain bytes at its own pace without losing characters during bursts. A sticky overflow flag records any byte dropped while the FIFO was full.

## Interface
- DBIT, 8: data width in bits; matches the receiver's data-bit count.
- ADDR_W, 4: address width; depth = 2^ADDR_W entries (16 by default).
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- rx_done_tck  input  1  one-cycle write strobe from the receiver; din valid in the same cycle.
- din  input  DBIT  received byte.
- rd  input  1  read/pop strobe from the consumer; pops the head entry at the clock edge.
- clr_overflow  input  1  clears the sticky overflow flag.
- dout  output  DBIT  head-of-FIFO byte (fall-through); 0 while empty.
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds 2^ADDR_W entries.
- count  output  ADDR_W+1  number of stored entries, 0..2^ADDR_W.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.

## Operation
- Storage: register array of 2^ADDR_W x DBIT. Write pointer wp and read pointer rp are ADDR_W bits wide and wrap modulo 2^ADDR_W. count is held in a register; empty = (count==0), full = (count==2^ADDR_W).
- Write acceptance: accepted when rx_done_tck=1 and (full=0 or rd=1). An accepted write stores din at mem[wp] and sets wp+1.
- Read acceptance: accepted when rd=1 and empty=0. An accepted read sets rp+1. rd while empty is ignored and has no side effects.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous read and write:
  - When empty: only the write is performed. The new byte appears on dout after the edge.
  - When full: both are performed; count stays 2^ADDR_W and the byte is not dropped.
  - Otherwise: both are performed and count is unchanged.
- Overflow: if rx_done_tck=1 while full=1 and rd=0, din is discarded, pointers and count are unchanged, and overflow is set to 1 at that edge.
- clr_overflow=1 clears overflow at the edge. If the set condition and clr_overflow occur in the same cycle, the set wins.
- dout = mem[rp] when empty=0, else 0. The output is purely combinational from registered state.
- Memory contents are not reset. Only pointers, count and overflow are reset.

## Timing
- Reset (sync, active-high, sampled at clk edge): wp=0, rp=0, count=0, empty=1, full=0, overflow=0, dout=0. Reset overrides all other inputs in the same cycle, including an in-progress burst; any stored bytes are abandoned.
- Write latency: a strobe at edge N makes the byte visible on dout, empty=0 and count updated immediately after edge N. A consumer may pop it at edge N+1.
- Read latency: rd at edge N advances the head; the next byte (or 0 with empty=1) appears after edge N.
- full asserts after the edge that accepts the 2^ADDR_W-th write. empty asserts after the edge that pops the last entry.
- Throughput: one write and one read per cycle sustained. The receiver strobes at most once per 10 bit-times, so the write side never back-pressures.
- No combinational path from rx_done_tck or rd to any output.

## Test plan
- Reset then idle: assert reset 2 cycles -> empty=1, full=0, count=0, dout=0, overflow=0; rd pulses while empty leave all outputs unchanged.
- Single byte: strobe din=0xA5 -> next cycle dout=0xA5, empty=0, count=1; pulse rd -> dout=0, empty=1, count=0.
- Fill and wrap: write 0x00..0x0F (16 bytes) -> full=1, count=16; read 8, write 0x10..0x17, then read 16 -> bytes 0x08..0x17 in order, empty=1 at end (pointer wrap verified).
- Overflow: with FIFO full, strobe din=0xEE, rd=0 -> overflow=1, count=16, 0xEE never appears on dout. Next, clr_overflow and a second overflow strobe in the same cycle -> overflow stays 1. Then clr_overflow alone -> overflow=0.
- Simultaneous ops:
  - Full plus rd and strobe with din=0x55 -> count stays 16; 0x55 is read last, and overflow stays 0.
  - Empty plus rd and strobe with din=0x33 -> dout=0x33, count=1.
- Reset mid-operation: with 5 entries stored, assert reset together with a strobe -> count=0, empty=1, overflow=0; the following write of 0x7E reads back as 0x7E.
